// File: rtl/mc_pkg.sv
// Shared types and helpers for the scan-path master timing controller.
// Holds the scan mode and raster state encodings plus the galvo strobe decode.
package mc_pkg;

    typedef enum logic [1:0] {
        MODE_CONT  = 2'd0,
        MODE_FRAME = 2'd1,
        MODE_LINE  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam int MAX_GO_PER_PIXEL = 8;

    // Returns j (1..go_per_pixel) when cnt is the final cycle of galvo
    // sub-interval j within a pixel, and 0 everywhere else.
    function automatic int go_slot(input int cnt, input int step, input int go_per_pixel);
        int slot;
        slot = 0;
        for (int j = 1; j <= MAX_GO_PER_PIXEL; j++) begin
            if (j <= go_per_pixel && cnt == j * step - 1) begin
                slot = j;
            end
        end
        return slot;
    endfunction

endpackage

// File: rtl/pixel_timebase.sv
// Free-running pixel timebase: cycle counter, pixel boundary, galvo strobe decode
// and the AWG sync divider. Runs in every raster state so AWG phase is never lost.
module pixel_timebase
    import mc_pkg::*;
#(
    parameter int PIXEL_SIZE   = 2000,
    parameter int GO_PER_PIXEL = 2,
    parameter int AWG_DIV      = 2
) (
    input  logic clk_adc,
    input  logic rst_adc_n,
    input  logic scan_active,
    input  logic arm_active,
    output logic tc,
    output logic last,
    output logic galvo_go,
    output logic sync_awg
);

    localparam int CNT_W = $clog2(PIXEL_SIZE);
    localparam int STEP  = PIXEL_SIZE / GO_PER_PIXEL;
    localparam int AWG_W = (AWG_DIV > 1) ? $clog2(AWG_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [AWG_W-1:0] awg_cnt;
    int               slot;
    logic             go_hit;

    assign tc = (cnt == CNT_W'(PIXEL_SIZE - 1));

    // While arming, only the pixel-end strobe is allowed so the galvo is
    // already stepping as the first scanned pixel begins.
    always_comb begin
        slot   = go_slot(int'(cnt), STEP, GO_PER_PIXEL);
        go_hit = (slot != 0) && (scan_active || (arm_active && slot == GO_PER_PIXEL));
    end

    always_ff @(posedge clk_adc or negedge rst_adc_n) begin
        if (!rst_adc_n) begin
            cnt      <= '0;
            last     <= 1'b0;
            galvo_go <= 1'b0;
        end else begin
            cnt      <= tc ? '0 : cnt + CNT_W'(1);
            last     <= tc;
            galvo_go <= go_hit;
        end
    end

    // The divider steps on the registered last, so sync_awg trails it by a cycle.
    always_ff @(posedge clk_adc or negedge rst_adc_n) begin
        if (!rst_adc_n) begin
            awg_cnt  <= '0;
            sync_awg <= 1'b0;
        end else begin
            sync_awg <= 1'b0;
            if (last) begin
                if (awg_cnt == AWG_W'(AWG_DIV - 1)) begin
                    awg_cnt  <= '0;
                    sync_awg <= 1'b1;
                end else begin
                    awg_cnt <= awg_cnt + AWG_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pixel_sequencer.sv
// Master scan timing controller: raster FSM (IDLE/ARM/SCAN), H/V position
// tracking and galvo SPI overrun detection on top of the pixel timebase.
module pixel_sequencer
    import mc_pkg::*;
#(
    parameter int PIXEL_SIZE   = 2000,
    parameter int GO_PER_PIXEL = 2,
    parameter int AWG_DIV      = 2,
    parameter int H_PIXELS     = 1024,
    parameter int V_LINES      = 1024,
    parameter int POS_W        = 11
) (
    input  logic             clk_adc,
    input  logic             rst_adc_n,
    input  logic             run,
    input  logic             halt,
    input  logic [1:0]       mode,
    input  logic             galvo_spi_done,
    output logic             sampling,
    output logic             last,
    output logic             galvo_go,
    output logic             sync_awg,
    output logic [POS_W-1:0] pos_h,
    output logic [POS_W-1:0] pos_v,
    output logic             line_end,
    output logic             frame_end,
    output logic             busy,
    output logic             galvo_overrun
);

    state_t state;
    mode_t  mode_q;
    logic   halt_pend;
    logic   go_pend;
    logic   tc;
    logic   accept_run;
    logic   line_wrap;
    logic   frame_wrap;
    logic   stop_scan;

    pixel_timebase #(
        .PIXEL_SIZE   (PIXEL_SIZE),
        .GO_PER_PIXEL (GO_PER_PIXEL),
        .AWG_DIV      (AWG_DIV)
    ) u_timebase (
        .clk_adc     (clk_adc),
        .rst_adc_n   (rst_adc_n),
        .scan_active (state == SCAN),
        .arm_active  (state == ARM),
        .tc          (tc),
        .last        (last),
        .galvo_go    (galvo_go),
        .sync_awg    (sync_awg)
    );

    // A halt arriving on the boundary cycle itself also ends the scan there.
    always_comb begin
        accept_run = (state == IDLE) && run && !halt;
        line_wrap  = (pos_h == POS_W'(H_PIXELS - 1));
        frame_wrap = line_wrap && (pos_v == POS_W'(V_LINES - 1));
        stop_scan  = halt_pend || halt
                  || (mode_q == MODE_LINE  && line_wrap)
                  || (mode_q == MODE_FRAME && frame_wrap);
    end

    always_ff @(posedge clk_adc or negedge rst_adc_n) begin
        if (!rst_adc_n) begin
            state     <= IDLE;
            mode_q    <= MODE_CONT;
            sampling  <= 1'b0;
            pos_h     <= '0;
            pos_v     <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_run) begin
                        state  <= ARM;
                        busy   <= 1'b1;
                        mode_q <= (mode == 2'd3) ? MODE_CONT : mode_t'(mode);
                    end
                end
                ARM: begin
                    if (halt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tc) begin
                        state    <= SCAN;
                        sampling <= 1'b1;
                        pos_h    <= '0;
                        pos_v    <= '0;
                    end
                end
                SCAN: begin
                    if (tc) begin
                        if (line_wrap) begin
                            pos_h    <= '0;
                            line_end <= 1'b1;
                            if (frame_wrap) begin
                                pos_v     <= '0;
                                frame_end <= 1'b1;
                            end else begin
                                pos_v <= pos_v + POS_W'(1);
                            end
                        end else begin
                            pos_h <= pos_h + POS_W'(1);
                        end
                        halt_pend <= 1'b0;
                        if (stop_scan) begin
                            state    <= IDLE;
                            sampling <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end else if (halt) begin
                        halt_pend <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A new strobe with the previous transfer still outstanding is an overrun;
    // a done in the same cycle retires the old transfer in time.
    always_ff @(posedge clk_adc or negedge rst_adc_n) begin
        if (!rst_adc_n) begin
            go_pend       <= 1'b0;
            galvo_overrun <= 1'b0;
        end else if (accept_run) begin
            go_pend       <= 1'b0;
            galvo_overrun <= 1'b0;
        end else begin
            if (galvo_go && go_pend && !galvo_spi_done) begin
                galvo_overrun <= 1'b1;
            end
            if (galvo_go) begin
                go_pend <= 1'b1;
            end else if (galvo_spi_done) begin
                go_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Bench for pixel_sequencer: table of stimulus rows with expected pulse tallies,
// plus a cycle scoreboard fed by a behavioural model of the scan timing.
module tb_pixel_sequencer;

    localparam int P   = 8;
    localparam int GO  = 2;
    localparam int AWG = 2;
    localparam int H   = 4;
    localparam int V   = 3;
    localparam int PW  = 11;
    localparam int S_IDLE = 0;
    localparam int S_ARM  = 1;
    localparam int S_SCAN = 2;

    logic          clk_adc;
    logic          rst_adc_n;
    logic          run;
    logic          halt;
    logic [1:0]    mode;
    logic          galvo_spi_done;
    logic          sampling;
    logic          last;
    logic          galvo_go;
    logic          sync_awg;
    logic [PW-1:0] pos_h;
    logic [PW-1:0] pos_v;
    logic          line_end;
    logic          frame_end;
    logic          busy;
    logic          galvo_overrun;

    typedef struct packed {
        logic          sampling;
        logic          last;
        logic          galvo_go;
        logic          sync_awg;
        logic [PW-1:0] pos_h;
        logic [PW-1:0] pos_v;
        logic          line_end;
        logic          frame_end;
        logic          busy;
        logic          galvo_overrun;
    } obs_t;

    typedef struct {
        string      name;
        logic       run;
        logic       halt;
        logic [1:0] mode;
        int         at_cnt;
        int         at_h;
        logic       ack;
        int         idle;
        int         e_last;
        int         e_sync;
        int         e_go;
        int         e_le;
        int         e_fe;
        int         e_samp;
        int         e_busy;
        int         e_ovr;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state: values the DUT registers hold during the current cycle
    int   m_state, m_mode, m_cnt, m_awg, m_h, m_v;
    bit   m_samp, m_last, m_go, m_sync, m_le, m_fe, m_busy, m_pend, m_hp, m_ovr;
    logic auto_done;
    logic prev_go;

    int t_last, t_sync, t_go, t_le, t_fe, t_samp;

    pixel_sequencer #(
        .PIXEL_SIZE   (P),
        .GO_PER_PIXEL (GO),
        .AWG_DIV      (AWG),
        .H_PIXELS     (H),
        .V_LINES      (V),
        .POS_W        (PW)
    ) dut (
        .clk_adc        (clk_adc),
        .rst_adc_n      (rst_adc_n),
        .run            (run),
        .halt           (halt),
        .mode           (mode),
        .galvo_spi_done (galvo_spi_done),
        .sampling       (sampling),
        .last           (last),
        .galvo_go       (galvo_go),
        .sync_awg       (sync_awg),
        .pos_h          (pos_h),
        .pos_v          (pos_v),
        .line_end       (line_end),
        .frame_end      (frame_end),
        .busy           (busy),
        .galvo_overrun  (galvo_overrun)
    );

    initial clk_adc = 1'b0;
    always #5 clk_adc = ~clk_adc;

    function automatic obs_t obsNow();
        obs_t o;
        o = '{sampling, last, galvo_go, sync_awg, pos_h, pos_v,
              line_end, frame_end, busy, galvo_overrun};
        return o;
    endfunction

    function automatic obs_t modelObs();
        obs_t o;
        o = '{m_samp, m_last, m_go, m_sync, PW'(m_h), PW'(m_v),
              m_le, m_fe, m_busy, m_ovr};
        return o;
    endfunction

    task automatic modelReset();
        m_state = S_IDLE; m_mode = 0; m_cnt = 0; m_awg = 0; m_h = 0; m_v = 0;
        m_samp = 0; m_last = 0; m_go = 0; m_sync = 0; m_le = 0; m_fe = 0;
        m_busy = 0; m_pend = 0; m_hp = 0; m_ovr = 0;
        prev_go = 1'b0;
    endtask

    task automatic modelStep(input logic r, input logic h, input logic [1:0] md, input logic d);
        bit tc, n_go, n_sync, lw, fw, hp;
        tc     = (m_cnt == P - 1);
        n_go   = (((m_cnt + 1) % (P / GO)) == 0) && (m_state == S_SCAN || (m_state == S_ARM && tc));
        n_sync = m_last && (m_awg == AWG - 1);
        if (m_last) m_awg = (m_awg + 1) % AWG;
        if (m_state == S_IDLE && r && !h) begin
            m_ovr = 0; m_pend = 0;
        end else begin
            if (m_go && m_pend && !d) m_ovr = 1;
            if (m_go) m_pend = 1;
            else if (d) m_pend = 0;
        end
        m_le = 0; m_fe = 0;
        case (m_state)
            S_IDLE: if (r && !h) begin
                m_state = S_ARM; m_busy = 1; m_mode = (md == 2'd3) ? 0 : int'(md);
            end
            S_ARM: if (h) begin
                m_state = S_IDLE; m_busy = 0;
            end else if (tc) begin
                m_state = S_SCAN; m_samp = 1; m_h = 0; m_v = 0;
            end
            default: begin
                hp = m_hp || h;
                if (tc) begin
                    lw = (m_h == H - 1);
                    fw = lw && (m_v == V - 1);
                    m_h = lw ? 0 : m_h + 1;
                    if (lw) m_v = fw ? 0 : m_v + 1;
                    m_le = lw; m_fe = fw; m_hp = 0;
                    if (hp || (m_mode == 2 && lw) || (m_mode == 1 && fw)) begin
                        m_state = S_IDLE; m_samp = 0; m_busy = 0;
                    end
                end else begin
                    m_hp = hp;
                end
            end
        endcase
        m_last = tc; m_go = n_go; m_sync = n_sync;
        m_cnt = (m_cnt + 1) % P;
    endtask

    task automatic checkValue(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        obs_t e, a;
        a = obsNow();
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("[TB] FAIL %s @%0t: got s%b l%b g%b a%b h%0d v%0d le%b fe%b b%b o%b, expected s%b l%b g%b a%b h%0d v%0d le%b fe%b b%b o%b",
                         tag, $time, a.sampling, a.last, a.galvo_go, a.sync_awg, a.pos_h, a.pos_v,
                         a.line_end, a.frame_end, a.busy, a.galvo_overrun,
                         e.sampling, e.last, e.galvo_go, e.sync_awg, e.pos_h, e.pos_v,
                         e.line_end, e.frame_end, e.busy, e.galvo_overrun);
            end
        end
    endtask

    // One clock of stimulus; galvo acks are returned the cycle after each strobe when enabled.
    task automatic applyStimulus(input logic r, input logic h, input logic [1:0] md, input string tag);
        logic d;
        logic cur_go;
        @(negedge clk_adc);
        cur_go = m_go;
        d = auto_done && prev_go;
        run = r; halt = h; mode = md; galvo_spi_done = d;
        modelStep(r, h, md, d);
        prev_go = cur_go;
        exp_q.push_back(modelObs());
        @(posedge clk_adc);
        #1;
        checkOutput(tag);
        t_last += int'(last);
        t_sync += int'(sync_awg);
        t_go   += int'(galvo_go);
        t_le   += int'(line_end);
        t_fe   += int'(frame_end);
        t_samp += int'(sampling);
    endtask

    task automatic clearTally();
        t_last = 0; t_sync = 0; t_go = 0; t_le = 0; t_fe = 0; t_samp = 0;
    endtask

    task automatic checkTally(input string name, input int act, input int expv);
        if (expv >= 0) checkValue(name, act, expv);
    endtask

    task automatic doReset(input int n);
        rst_adc_n = 1'b0;
        run = 0; halt = 0; mode = 0; galvo_spi_done = 0;
        modelReset();
        exp_q.delete();
        #1;
        checkValue("reset_async", int'(obsNow()), 0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_adc);
            #1;
            checkValue("reset_hold", int'(obsNow()), 0);
        end
        rst_adc_n = 1'b1;
    endtask

    task automatic waitFor(input int at_cnt, input int at_h, input string tag);
        int guard;
        guard = 0;
        while (!(m_cnt == at_cnt && (at_h < 0 || m_h == at_h)) && guard < 64) begin
            applyStimulus(1'b0, 1'b0, 2'd0, {tag, "_wait"});
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait: position not reached, cnt %0d h %0d, wanted cnt %0d h %0d",
                     tag, m_cnt, m_h, at_cnt, at_h);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //          name          run halt mode cnt  h ack idle last sync go le fe samp busy ovr
        vecs[0]  = '{"free",      0, 0, 2'd0, -1, -1, 1, 47,  6,  2,  0, 0, 0,   0, 0, 0};
        vecs[1]  = '{"frame",     1, 0, 2'd1,  3, -1, 1, 110, 14, -1, 25, 3, 1,  96, 0, 0};
        vecs[2]  = '{"cont",      1, 0, 2'd0,  0, -1, 1, 130, 16, -1, 31, 3, 1, 124, 1, 0};
        vecs[3]  = '{"run_scan",  1, 0, 2'd1,  5, -1, 1, 9,  -1, -1, -1, -1, -1, 10, 1, 0};
        vecs[4]  = '{"halt_scan", 0, 1, 2'd0,  2,  1, 1, 15,  2, -1, -1, 0, 0,   5, 0, 0};
        vecs[5]  = '{"run_halt",  1, 1, 2'd0,  1, -1, 1, 9,  -1, -1,  0, 0, 0,   0, 0, 0};
        vecs[6]  = '{"arm",       1, 0, 2'd2,  1, -1, 1, 1,  -1, -1,  0, 0, 0,   0, 1, 0};
        vecs[7]  = '{"halt_arm",  0, 1, 2'd0, -1, -1, 1, 11, -1, -1,  0, 0, 0,   0, 0, 0};
        vecs[8]  = '{"overrun",   1, 0, 2'd3,  0, -1, 0, 40, -1, -1, -1, -1, -1, -1, 1, 1};
        vecs[9]  = '{"halt_ovr",  0, 1, 2'd0, -1, -1, 1, 15, -1, -1, -1, -1, -1, -1, 0, 1};
        vecs[10] = '{"line",      1, 0, 2'd2,  4, -1, 1, 50, -1, -1, -1, 1, 0,  32, 0, 0};

        rst_adc_n = 1'b1; run = 0; halt = 0; mode = 0; galvo_spi_done = 0;
        auto_done = 1'b1;
        modelReset();
        #2;
        doReset(3);

        for (int i = 0; i < 11; i++) begin
            auto_done = vecs[i].ack;
            if (vecs[i].at_cnt >= 0) waitFor(vecs[i].at_cnt, vecs[i].at_h, vecs[i].name);
            clearTally();
            applyStimulus(vecs[i].run, vecs[i].halt, vecs[i].mode, vecs[i].name);
            for (int k = 0; k < vecs[i].idle; k++) begin
                applyStimulus(1'b0, 1'b0, 2'd0, vecs[i].name);
            end
            checkTally({vecs[i].name, "_last"},  t_last, vecs[i].e_last);
            checkTally({vecs[i].name, "_sync"},  t_sync, vecs[i].e_sync);
            checkTally({vecs[i].name, "_go"},    t_go,   vecs[i].e_go);
            checkTally({vecs[i].name, "_lend"},  t_le,   vecs[i].e_le);
            checkTally({vecs[i].name, "_fend"},  t_fe,   vecs[i].e_fe);
            checkTally({vecs[i].name, "_samp"},  t_samp, vecs[i].e_samp);
            checkTally({vecs[i].name, "_busy"},  int'(busy),          vecs[i].e_busy);
            checkTally({vecs[i].name, "_ovr"},   int'(galvo_overrun), vecs[i].e_ovr);
        end

        // Reset in the middle of a continuous scan, then the timebase restarts from zero.
        auto_done = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, "pre_reset_run");
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 2'd0, "pre_reset");
        checkValue("pre_reset_sampling", int'(sampling), 1);
        doReset(2);
        clearTally();
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b0, 2'd0, "post_reset");
        checkValue("post_reset_last", t_last, 2);
        checkValue("post_reset_samp", t_samp, 0);
        checkValue("post_reset_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
